// File: rtl/beam_sweep_ctrl_if.sv
// Configuration bus of the beam-steering sequencer: table write request
// with one-cycle accept/reject response.
interface beam_sweep_ctrl_if #(
  parameter int AW = 4
);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [19:0]   cfg_wdata;
  logic          cfg_ack;
  logic          cfg_err;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_ack,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_ack,
    output cfg_err
  );
endinterface

// File: rtl/beam_sweep_ctrl.sv
// Beam-steering sequencer: steps a programmable weight table into the
// two-beam phase shifter with a per-entry dwell, single-shot or continuous.
module beam_sweep_ctrl #(
  parameter int AW = 4,
  parameter int DW = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  beam_sweep_ctrl_if.slave   cfg,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [AW-1:0]      last_idx,
  input  logic [DW-1:0]      dwell,
  output logic [4:0]         w_cos_1,
  output logic [4:0]         w_sin_1,
  output logic [4:0]         w_cos_2,
  output logic [4:0]         w_sin_2,
  output logic [AW-1:0]      step_idx,
  output logic               step_strobe,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] CNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] CNT_ONE  = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] idx_r;
  logic [DW-1:0] cnt_r;
  logic          cont_r;
  logic [AW-1:0] last_r;
  logic [DW-1:0] dwell_r;
  logic [19:0]   table_r [DEPTH];
  logic          ack_r;
  logic          err_r;

  logic          launch_s;
  logic          load_s;
  logic          advance_s;
  logic          wrap_s;
  logic          done_s;
  logic          wr_ok_s;

  assign wr_ok_s     = cfg.cfg_we & (state_r == ST_IDLE);
  assign cfg.cfg_ack = ack_r;
  assign cfg.cfg_err = err_r;

  // Next-state and step-control decode; stop always takes priority.
  always_comb begin
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    wrap_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt_s = ST_FETCH;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DWELL;
          load_s      = 1'b1;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          if (idx_r != last_r) begin
            state_nxt_s = ST_FETCH;
            advance_s   = 1'b1;
          end else if (cont_r) begin
            state_nxt_s = ST_FETCH;
            wrap_s      = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
            done_s      = 1'b1;
          end
        end else begin
          state_nxt_s = ST_DWELL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, sweep parameters, index and dwell counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
      cont_r  <= 1'b0;
      last_r  <= IDX_ZERO;
      dwell_r <= CNT_ZERO;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != ST_IDLE);
      done    <= done_s;
      if (launch_s) begin
        idx_r   <= IDX_ZERO;
        cont_r  <= continuous;
        last_r  <= last_idx;
        dwell_r <= (dwell == CNT_ZERO) ? CNT_ONE : dwell;
      end else if (advance_s) begin
        idx_r <= idx_r + IDX_ONE;
      end else if (wrap_s) begin
        idx_r <= IDX_ZERO;
      end else begin
        idx_r <= idx_r;
      end
      // The FETCH cycle itself is one of the dwell_r+1 cycles of a step.
      if (load_s) begin
        cnt_r <= dwell_r - CNT_ONE;
      end else if ((state_r == ST_DWELL) && (cnt_r != CNT_ZERO)) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Weight and index output registers, loaded at the close of FETCH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_cos_1     <= 5'd0;
      w_sin_1     <= 5'd0;
      w_cos_2     <= 5'd0;
      w_sin_2     <= 5'd0;
      step_idx    <= IDX_ZERO;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= load_s;
      if (load_s) begin
        {w_cos_1, w_sin_1, w_cos_2, w_sin_2} <= table_r[idx_r];
        step_idx <= idx_r;
      end else begin
        step_idx <= step_idx;
      end
    end
  end

  // Weight table and configuration-bus response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= 20'd0;
      end
      ack_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      ack_r <= wr_ok_s;
      err_r <= cfg.cfg_we & ~wr_ok_s;
      if (wr_ok_s) begin
        table_r[cfg.cfg_addr] <= cfg.cfg_wdata;
      end else begin
        table_r[cfg.cfg_addr] <= table_r[cfg.cfg_addr];
      end
    end
  end

endmodule

// File: tb/tb_beam_sweep_ctrl.sv
// Bench for beam_sweep_ctrl: idle-bus vector table, directed sweeps and
// randomized sweeps checked against a cycle-arithmetic reference model.
module tb_beam_sweep_ctrl;
  localparam int AW = 4;
  localparam int DW = 12;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start, stop, continuous;
  logic [AW-1:0] last_idx;
  logic [DW-1:0] dwell;
  logic [4:0]    w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic [AW-1:0] step_idx;
  logic          step_strobe, busy, done;

  beam_sweep_ctrl_if #(.AW(AW)) cfg_bus ();

  beam_sweep_ctrl #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n), .cfg(cfg_bus),
    .start(start), .stop(stop), .continuous(continuous),
    .last_idx(last_idx), .dwell(dwell),
    .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2),
    .step_idx(step_idx), .step_strobe(step_strobe), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [19:0] tbl_m [16];
  logic [19:0] w_hold_m;
  logic [3:0]  idx_hold_m;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [19:0] wdata;
    logic        st;
    logic        sp;
    logic        exp_ack;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [28:0] outs();
    return {w_cos_1, w_sin_1, w_cos_2, w_sin_2, step_idx, step_strobe, busy, done,
            cfg_bus.cfg_ack, cfg_bus.cfg_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; continuous = 1'b0;
    last_idx = 4'd0; dwell = 12'd0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = 4'd0; cfg_bus.cfg_wdata = 20'd0;
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [19:0] data);
    cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = addr; cfg_bus.cfg_wdata = data;
    tick();
    cfg_bus.cfg_we = 1'b0;
    tbl_m[addr] = data;
    check("idle_write_ack_err", {30'd0, cfg_bus.cfg_ack, cfg_bus.cfg_err}, 32'd2);
  endtask

  // Cycle c = c-th cycle after the edge that samples start.
  task automatic run_sweep(input int last, input int dw, input bit cont, input int stop_at,
                           input int restart_at, input int busy_we_at, input bit we0,
                           input logic [3:0] we0_addr, input logic [19:0] we0_data);
    int p, total, end_c, m, idx;
    logic [19:0] w_e;
    logic [3:0]  i_e;
    logic        strb_e, busy_e, done_e, ack_e, err_e;
    logic [31:0] r;
    p     = ((dw == 0) ? 1 : dw) + 1;
    total = (last + 1) * p;
    end_c = (stop_at > 0) ? stop_at : total;
    start = 1'b1; continuous = cont; last_idx = last[3:0]; dwell = dw[DW-1:0];
    if (we0) begin
      cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = we0_addr; cfg_bus.cfg_wdata = we0_data;
      tbl_m[we0_addr] = we0_data;
    end
    for (int c = 1; c <= end_c + 2; c++) begin
      tick();
      m = (c < end_c) ? c : end_c;
      if (m >= 2) begin
        idx = ((m - 2) / p) % (last + 1);
        w_e = tbl_m[idx];
        i_e = idx[3:0];
      end else begin
        w_e = w_hold_m;
        i_e = idx_hold_m;
      end
      strb_e = (c >= 2) && (c <= end_c) && (((c - 2) % p) == 0);
      busy_e = (c <= end_c);
      done_e = (stop_at == 0) && !cont && (c == total + 1);
      ack_e  = we0 && (c == 1);
      err_e  = (busy_we_at > 0) && (c == busy_we_at + 1);
      check($sformatf("sweep_l%0d_d%0d_k%0d_s%0d_c%0d", last, dw, cont, stop_at, c),
            {3'd0, outs()}, {3'd0, w_e, i_e, strb_e, busy_e, done_e, ack_e, err_e});
      start = (c == restart_at);
      stop  = (c == stop_at);
      cfg_bus.cfg_we = (c == busy_we_at);
      r = $urandom;
      cfg_bus.cfg_addr  = r[23:20];
      cfg_bus.cfg_wdata = r[19:0];
    end
    if (end_c >= 2) begin
      idx        = ((end_c - 2) / p) % (last + 1);
      idx_hold_m = idx[3:0];
      w_hold_m   = tbl_m[idx];
    end
    idle_inputs();
  endtask

  initial begin
    int last, dw, p, total, end_c, stop_at, restart_at, busy_we_at;
    bit cont, we0;
    logic [31:0] r;

    for (int i = 0; i < 16; i++) tbl_m[i] = 20'd0;
    w_hold_m = 20'd0; idx_hold_m = 4'd0;
    reset_n = 1'b0;
    idle_inputs();
    #12;
    check("reset_outputs", {3'd0, outs()}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", {3'd0, outs()}, 32'd0);

    vecs[0] = '{1'b1, 4'd0, 20'h00001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd1, 20'h00002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'd2, 20'h00003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'd0, 20'h00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 20'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 4'd5, 20'h12345, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'd0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    last_idx = 4'd3; dwell = 12'd2;
    for (int i = 0; i < 8; i++) begin
      cfg_bus.cfg_we = vecs[i].we; cfg_bus.cfg_addr = vecs[i].addr;
      cfg_bus.cfg_wdata = vecs[i].wdata; start = vecs[i].st; stop = vecs[i].sp;
      tick();
      if (vecs[i].we) tbl_m[vecs[i].addr] = vecs[i].wdata;
      check($sformatf("vec%0d_ack_err_busy", i),
            {29'd0, cfg_bus.cfg_ack, cfg_bus.cfg_err, busy},
            {29'd0, vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_busy});
    end
    idle_inputs();

    // Single shot over entries 0..2, dwell 3: strobes 2/6/10, done at 13.
    run_sweep(2, 3, 1'b0, 0, 0, 0, 1'b0, 4'd0, 20'd0);
    check("single_hold_sin2", {27'd0, w_sin_2}, 32'd3);
    check("single_idle_busy", {31'd0, busy}, 32'd0);

    // Continuous with dwell 0 treated as 1, then stopped.
    run_sweep(1, 0, 1'b1, 9, 0, 0, 1'b0, 4'd0, 20'd0);
    // Write while busy is rejected and the old entry 0 survives.
    run_sweep(0, 4, 1'b0, 0, 0, 3, 1'b0, 4'd0, 20'd0);
    run_sweep(0, 1, 1'b0, 0, 0, 0, 1'b0, 4'd0, 20'd0);
    check("busy_write_kept_entry0", {12'd0, w_cos_1, w_sin_1, w_cos_2, w_sin_2}, 32'h00001);
    // Same-cycle write and start: step 0 sees the new data.
    run_sweep(0, 2, 1'b0, 0, 0, 0, 1'b1, 4'd0, 20'hFFFFF);
    check("same_cycle_cos1", {27'd0, w_cos_1}, 32'h1F);
    // Start mid-sweep ignored; stop on final completion suppresses done.
    run_sweep(2, 2, 1'b0, 0, 5, 0, 1'b0, 4'd0, 20'd0);
    run_sweep(1, 1, 1'b0, 4, 0, 0, 1'b0, 4'd0, 20'd0);

    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < 3; w++) begin
        r = $urandom;
        write_entry(r[23:20], r[19:0]);
      end
      last = $urandom_range(0, 7);
      dw   = $urandom_range(0, 6);
      cont = ($urandom_range(0, 1) == 1);
      p     = ((dw == 0) ? 1 : dw) + 1;
      total = (last + 1) * p;
      if (cont) stop_at = $urandom_range(1, 40);
      else if ($urandom_range(0, 3) == 0) stop_at = $urandom_range(1, total);
      else stop_at = 0;
      end_c = (stop_at > 0) ? stop_at : total;
      restart_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, end_c) : 0;
      busy_we_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, end_c) : 0;
      we0 = ($urandom_range(0, 2) == 0);
      r = $urandom;
      run_sweep(last, dw, cont, stop_at, restart_at, busy_we_at, we0, r[23:20], r[19:0]);
    end

    // Asynchronous reset in the middle of a continuous sweep.
    start = 1'b1; continuous = 1'b1; last_idx = 4'd3; dwell = 12'd5;
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {3'd0, outs()}, 32'd0);
    #3;
    reset_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < 16; i++) tbl_m[i] = 20'd0;
    w_hold_m = 20'd0; idx_hold_m = 4'd0;
    tick();
    check("after_reset_idle", {3'd0, outs()}, 32'd0);
    run_sweep(3, 0, 1'b0, 0, 0, 0, 1'b0, 4'd0, 20'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
